// File: rtl/fibo_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fibo_pkg
// Brief    : shared types and default widths for the Fibonacci request path
// Revision : 1.0
// ============================================================================
package fibo_pkg;

  localparam int c_data_width    = 64;
  localparam int c_order_width   = 16;
  localparam int c_timeout_width = 20;

  typedef enum logic [1:0] {
    RSP_OK       = 2'b00,
    RSP_ERROR    = 2'b01,
    RSP_OVERFLOW = 2'b10,
    RSP_TIMEOUT  = 2'b11
  } rsp_status_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD1 = 3'd1,
    ST_LOAD2 = 3'd2,
    ST_WAIT  = 3'd3,
    ST_CLEAR = 3'd4,
    ST_RESP  = 3'd5
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/fibo_wdog.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fibo_wdog
// Brief    : WAIT-state watchdog counter with enable and synchronous clear
// Revision : 1.0
// ============================================================================
module fibo_wdog
  import fibo_pkg::*;
#(
  parameter int TIMEOUT_WIDTH = c_timeout_width
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic expired
);

  // The increment that lands on all-ones happens in the expiring cycle.
  localparam logic [TIMEOUT_WIDTH-1:0] c_last = ~TIMEOUT_WIDTH'(1);

  logic [TIMEOUT_WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign expired = en && (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/fibo_req_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fibo_req_seq
// Brief    : request/response sequencer driving the Fibonacci generator
// Revision : 1.0
// ============================================================================
module fibo_req_seq
  import fibo_pkg::*;
#(
  parameter int DATA_WIDTH    = c_data_width,
  parameter int ORDER_WIDTH   = c_order_width,
  parameter int TIMEOUT_WIDTH = c_timeout_width
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [DATA_WIDTH-1:0]  req_data,
  input  logic [ORDER_WIDTH-1:0] req_order,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_WIDTH-1:0]  rsp_data,
  output logic [1:0]             rsp_status,
  output logic                   gen_load,
  output logic                   gen_clear,
  output logic [DATA_WIDTH-1:0]  gen_data,
  output logic [ORDER_WIDTH-1:0] gen_order,
  input  logic                   gen_done,
  input  logic                   gen_error,
  input  logic                   gen_overflow,
  input  logic [DATA_WIDTH-1:0]  gen_result
);

  seq_state_t             r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0]  r_data, w_data_nxt;
  logic [ORDER_WIDTH-1:0] r_order, w_order_nxt;
  logic [DATA_WIDTH-1:0]  r_result, w_result_nxt;
  rsp_status_t            r_status, w_status_nxt;

  logic                   w_req_ready_nxt;
  logic                   w_rsp_valid_nxt;
  logic                   w_gen_load_nxt;
  logic                   w_gen_clear_nxt;
  logic                   w_hold;
  logic [DATA_WIDTH-1:0]  w_gen_data_nxt;
  logic [ORDER_WIDTH-1:0] w_gen_order_nxt;

  logic                   w_wdog_en;
  logic                   w_wdog_clr;
  logic                   w_wdog_expired;

  assign w_wdog_en  = (r_state == ST_WAIT);
  assign w_wdog_clr = (r_state == ST_RESP) && rsp_ready;

  fibo_wdog #(
    .TIMEOUT_WIDTH(TIMEOUT_WIDTH)
  ) u_wdog (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (w_wdog_en),
    .clr     (w_wdog_clr),
    .expired (w_wdog_expired)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_data_nxt   = r_data;
    w_order_nxt  = r_order;
    w_result_nxt = r_result;
    w_status_nxt = r_status;

    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_data_nxt  = req_data;
          w_order_nxt = req_order;
          w_state_nxt = ST_LOAD1;
        end
      end
      ST_LOAD1: w_state_nxt = ST_LOAD2;
      ST_LOAD2: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        // done > overflow > error > watchdog
        if (gen_done) begin
          w_result_nxt = gen_result;
          w_status_nxt = RSP_OK;
          w_state_nxt  = ST_RESP;
        end else if (gen_overflow) begin
          w_result_nxt = gen_result;
          w_status_nxt = RSP_OVERFLOW;
          w_state_nxt  = ST_CLEAR;
        end else if (gen_error) begin
          w_result_nxt = '0;
          w_status_nxt = RSP_ERROR;
          w_state_nxt  = ST_CLEAR;
        end else if (w_wdog_expired) begin
          w_result_nxt = '0;
          w_status_nxt = RSP_TIMEOUT;
          w_state_nxt  = ST_CLEAR;
        end
      end
      ST_CLEAR: w_state_nxt = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // The generator samples order during its ADD state, so hold through WAIT.
    w_hold = (w_state_nxt == ST_LOAD1) || (w_state_nxt == ST_LOAD2) ||
             (w_state_nxt == ST_WAIT);

    w_gen_data_nxt  = w_hold ? w_data_nxt  : '0;
    w_gen_order_nxt = w_hold ? w_order_nxt : '0;
    w_req_ready_nxt = (w_state_nxt == ST_IDLE);
    w_rsp_valid_nxt = (w_state_nxt == ST_RESP);
    w_gen_load_nxt  = (w_state_nxt == ST_LOAD1) || (w_state_nxt == ST_LOAD2);
    w_gen_clear_nxt = (w_state_nxt == ST_CLEAR);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_data    <= '0;
      r_order   <= '0;
      r_result  <= '0;
      r_status  <= RSP_OK;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      gen_load  <= 1'b0;
      gen_clear <= 1'b0;
      gen_data  <= '0;
      gen_order <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_data    <= w_data_nxt;
      r_order   <= w_order_nxt;
      r_result  <= w_result_nxt;
      r_status  <= w_status_nxt;
      req_ready <= w_req_ready_nxt;
      rsp_valid <= w_rsp_valid_nxt;
      gen_load  <= w_gen_load_nxt;
      gen_clear <= w_gen_clear_nxt;
      gen_data  <= w_gen_data_nxt;
      gen_order <= w_gen_order_nxt;
    end
  end

  assign rsp_data   = r_result;
  assign rsp_status = r_status;

endmodule
`default_nettype wire

// File: doc/fibo_req_seq.md
# fibo_req_seq

Request sequencer that sits directly upstream of the Fibonacci number-generator FSM. It accepts one `{data, order}` request at a time over a valid/ready handshake and drives the generator's `load`/`clear`/`data_in`/`order` pins with the required two-cycle load protocol. It waits for `done`, `error` or `overflow`, clears the generator after a fault, and returns the result with a status code over a valid/ready response channel. A watchdog recovers from a generator that never finishes.

## Interface
- DATA_WIDTH, 64, operand/result width
- ORDER_WIDTH, 16, sequence-position width
- TIMEOUT_WIDTH, 20, watchdog counter width; timeout after 2^TIMEOUT_WIDTH-1 WAIT cycles
- clk  in  1  clock, all logic on rising edge
- reset_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept
- req_data  in  DATA_WIDTH  seed value
- req_order  in  ORDER_WIDTH  requested position
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  DATA_WIDTH  result (OK/OVERFLOW: generator data_out; ERROR/TIMEOUT: 0)
- rsp_status  out  2  00 OK, 01 ERROR, 10 OVERFLOW, 11 TIMEOUT
- gen_load  out  1  to generator load
- gen_clear  out  1  to generator clear
- gen_data  out  DATA_WIDTH  to generator data_in
- gen_order  out  ORDER_WIDTH  to generator order
- gen_done, gen_error, gen_overflow  in  1 each  generator status
- gen_result  in  DATA_WIDTH  generator data_out

## Operation
- **Reset values:**
  - State IDLE; all outputs 0 except `req_ready`=1.
  - Captured data, order, status, result and watchdog registers are 0.
- **State machine:** IDLE, LOAD1, LOAD2, WAIT, CLEAR, RESP.
- **IDLE:**
  - `req_ready`=1.
  - On `req_valid`, capture `req_data`/`req_order` into registers and go to LOAD1.
  - No validation here; zero data or zero order is passed through, and the generator reports it as an error.
- **LOAD1, LOAD2:** `gen_load`=1 in both, then go to WAIT. `gen_load` is high for exactly two consecutive cycles per request.
- **gen_data/gen_order hold:** driven from the captured registers from LOAD1 until leaving WAIT, because the generator samples `order` during its ADD state. 0 otherwise.
- **WAIT:** the watchdog counter increments each cycle. Exits, in priority order:
  - `gen_done`: capture `gen_result`, status OK, go to RESP.
  - `gen_overflow`: capture `gen_result`, status OVERFLOW, go to CLEAR.
  - `gen_error`: result 0, status ERROR, go to CLEAR.
  - Counter reaches all-ones: result 0, status TIMEOUT, go to CLEAR.
- **CLEAR:** `gen_clear`=1 for one cycle, then go to RESP.
- **RESP:**
  - `rsp_valid`=1; `rsp_data`/`rsp_status` come from registers and are stable while `rsp_valid` is high.
  - On `rsp_ready`, go to IDLE and zero the watchdog.
- **Simultaneous events:**
  - Multiple generator status bits in the same cycle: priority done > overflow > error; timeout loses to any status bit.
  - `req_valid` outside IDLE is ignored (`req_ready`=0). No request is lost: the requester holds it.
- **Reset mid-operation:** immediate return to reset values. The generator shares `reset_n`, so no clear is issued.
- **Response ordering:** exactly one response per accepted request, in order.

## Timing
- Request accepted at edge e0 (`req_valid`&`req_ready`). `gen_load` is high in cycles 1–2 and the generator enters ADD at e2.
- order=1: `gen_done` in cycle 4, `rsp_valid` in cycle 5. Minimum accept→response latency is 5 cycles.
- Error (data 0): `gen_error` in cycle 3, `gen_clear` in cycle 4, `rsp_valid` in cycle 5.
- Overflow: `rsp_valid` 2 cycles after `gen_overflow` is first seen.
- RESP→IDLE takes 1 cycle after the `rsp_ready` handshake, so back-to-back request throughput is one per (latency+1) cycles.
- `rsp_ready` held high before `rsp_valid`: the response completes in its first valid cycle.

## Structure
- Shared package `fibo_pkg`:
  - `rsp_status_t` enum (OK, ERROR, OVERFLOW, TIMEOUT).
  - Sequencer state enum.
  - Default width constants.
- One natural sub-module, `fibo_wdog`: a TIMEOUT_WIDTH counter with enable and synchronous clear, producing an `expired` output.
- Everything else lives in a single FSM module with registered outputs.

## Test plan
- data=1, order=1, stub asserts `gen_done` with `gen_result`=0x1 → `gen_load` high exactly cycles 1–2; `rsp_valid` at cycle 5 with data 0x1, status 00.
- data=0, order=5 → stub `gen_error`; one-cycle `gen_clear`; response data 0, status 01; next request accepted afterwards.
- Stub raises `gen_overflow` with `gen_result`=0xFFFF_FFFF_FFFF_FFFF → `gen_clear` pulse; response data all-ones, status 10.
- TIMEOUT_WIDTH=4, stub silent → after 15 WAIT cycles, `gen_clear` pulse and response status 11, data 0.
- `rsp_ready` held low 10 cycles with a second `req_valid` pending → response stable, `req_ready`=0 throughout; second request accepted 1 cycle after the handshake.
- `reset_n` pulled low in WAIT → all outputs reset asynchronously; `req_ready`=1 on the first edge after release.
